// File: rtl/sram_banked_wrapper.sv
// Word-addressed memory of BANK_COUNT interleaved single-port SRAM banks. It has a
// masked RW primary port, a read-only secondary port, fair same-bank arbitration and a post-reset clear sweep.

module sram_banked_wrapper_bank #(
  parameter int BYTE_COUNT = 4,
  parameter int ROW_BITS   = 7
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [BYTE_COUNT-1:0]      mask,
  input  logic [ROW_BITS-1:0]        row,
  input  logic [BYTE_COUNT-1:0][7:0] wdata,
  output logic [BYTE_COUNT-1:0][7:0] rdata
);
  localparam int DEPTH = 2**ROW_BITS;

  logic [BYTE_COUNT-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we)
      for (int i = 0; i < BYTE_COUNT; i++)
        if (mask[i]) mem[row][i] <= wdata[i];
  end

  always_ff @(posedge clk) begin
    if (en && !we) rdata <= mem[row];
  end
endmodule

module sram_banked_wrapper #(
  parameter int BYTE_COUNT     = 4,
  parameter int ADDRESS_SIZE   = 9,
  parameter int BANK_COUNT     = 4,
  parameter int CLEAR_ON_RESET = 1,
  localparam int WORD_SIZE     = 8*BYTE_COUNT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    primarySelect,
  input  logic                    primaryWriteEnable,
  input  logic [BYTE_COUNT-1:0]   primaryWriteMask,
  input  logic [ADDRESS_SIZE-1:0] primaryAddress,
  input  logic [WORD_SIZE-1:0]    primaryDataWrite,
  output logic                    primaryBusy,
  output logic [WORD_SIZE-1:0]    primaryDataRead,
  output logic                    primaryReadValid,
  input  logic                    secondarySelect,
  input  logic [ADDRESS_SIZE-1:0] secondaryAddress,
  output logic                    secondaryBusy,
  output logic [WORD_SIZE-1:0]    secondaryDataRead,
  output logic                    secondaryReadValid,
  output logic                    clearing
);
  localparam int BANK_BITS = $clog2(BANK_COUNT);
  localparam int ROW_BITS  = ADDRESS_SIZE - BANK_BITS;
  localparam logic [ROW_BITS-1:0] LAST_ROW = '1;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [BYTE_COUNT-1:0] mask;
    logic [ROW_BITS-1:0]   row;
    logic [WORD_SIZE-1:0]  wdata;
  } bank_req_t;

  state_t                               state_q, state_d;
  logic [ROW_BITS-1:0]                  clr_row_q;
  logic                                 prio_sec_q;
  logic                                 ready, conflict, p_acc, s_acc;
  logic [BANK_BITS-1:0]                 p_bank, s_bank, p_bank_q, s_bank_q;
  logic                                 p_vld_q, s_vld_q;
  logic [WORD_SIZE-1:0]                 p_hold_q, s_hold_q;
  bank_req_t [BANK_COUNT-1:0]           bank_req;
  logic [BANK_COUNT-1:0][WORD_SIZE-1:0] bank_rdata;

  assign p_bank   = primaryAddress[BANK_BITS-1:0];
  assign s_bank   = secondaryAddress[BANK_BITS-1:0];
  assign ready    = rst && (state_q == ST_READY);
  assign clearing = rst && (state_q == ST_CLEAR);
  assign conflict = primarySelect && secondarySelect && (p_bank == s_bank);

  // prio_sec_q: secondary lost a conflict last cycle, so it wins the next one
  assign primaryBusy   = rst && primarySelect   && (!ready || (conflict &&  prio_sec_q));
  assign secondaryBusy = rst && secondarySelect && (!ready || (conflict && !prio_sec_q));
  assign p_acc = ready && primarySelect   && !primaryBusy;
  assign s_acc = ready && secondarySelect && !secondaryBusy;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: if (clr_row_q == LAST_ROW) state_d = ST_READY;
      default:  state_d = state_q;
    endcase
  end

  // Holds at the last row once the sweep is done; only reset rewinds it
  always_ff @(posedge clk) begin
    if (!rst)
      clr_row_q <= '0;
    else if (state_q == ST_CLEAR && clr_row_q != LAST_ROW)
      clr_row_q <= clr_row_q + 1'b1;
  end

  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      bank_req[b] = '0;
      if (clearing) begin
        bank_req[b].en   = 1'b1;
        bank_req[b].we   = 1'b1;
        bank_req[b].mask = '1;
        bank_req[b].row  = clr_row_q;
      end else if (p_acc && p_bank == BANK_BITS'(b)) begin
        bank_req[b].en    = 1'b1;
        bank_req[b].we    = primaryWriteEnable;
        bank_req[b].mask  = primaryWriteMask;
        bank_req[b].row   = primaryAddress[ADDRESS_SIZE-1:BANK_BITS];
        bank_req[b].wdata = primaryDataWrite;
      end else if (s_acc && s_bank == BANK_BITS'(b)) begin
        bank_req[b].en  = 1'b1;
        bank_req[b].row = secondaryAddress[ADDRESS_SIZE-1:BANK_BITS];
      end
    end
  end

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    sram_banked_wrapper_bank #(
      .BYTE_COUNT (BYTE_COUNT),
      .ROW_BITS   (ROW_BITS)
    ) u_bank (
      .clk   (clk),
      .en    (bank_req[b].en),
      .we    (bank_req[b].we),
      .mask  (bank_req[b].mask),
      .row   (bank_req[b].row),
      .wdata (bank_req[b].wdata),
      .rdata (bank_rdata[b])
    );
  end

  // Bank read registers can be overwritten by the other port, so each port keeps its own copy
  always_ff @(posedge clk) begin
    if (!rst) begin
      p_vld_q    <= 1'b0;
      s_vld_q    <= 1'b0;
      p_bank_q   <= '0;
      s_bank_q   <= '0;
      p_hold_q   <= '0;
      s_hold_q   <= '0;
      prio_sec_q <= 1'b0;
    end else begin
      p_vld_q    <= p_acc && !primaryWriteEnable;
      s_vld_q    <= s_acc;
      if (p_acc) p_bank_q <= p_bank;
      if (s_acc) s_bank_q <= s_bank;
      if (p_vld_q) p_hold_q <= bank_rdata[p_bank_q];
      if (s_vld_q) s_hold_q <= bank_rdata[s_bank_q];
      prio_sec_q <= ready && conflict && !prio_sec_q;
    end
  end

  assign primaryReadValid   = p_vld_q;
  assign secondaryReadValid = s_vld_q;
  assign primaryDataRead    = p_vld_q ? bank_rdata[p_bank_q] : p_hold_q;
  assign secondaryDataRead  = s_vld_q ? bank_rdata[s_bank_q] : s_hold_q;
endmodule

// File: tb/tb_sram_banked_wrapper.sv
// Bench for sram_banked_wrapper: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a word-array model of the memory.

module tb_sram_banked_wrapper;
  localparam int BC = 4, AS = 6, BK = 4, ROWS = 16, WORDS = 64;

  logic        clk = 1'b0, rst = 1'b0;
  logic        primarySelect = 1'b0, primaryWriteEnable = 1'b0;
  logic [3:0]  primaryWriteMask = '0;
  logic [5:0]  primaryAddress = '0, secondaryAddress = '0;
  logic [31:0] primaryDataWrite = '0;
  logic        secondarySelect = 1'b0;
  logic        primaryBusy, secondaryBusy, primaryReadValid, secondaryReadValid, clearing;
  logic [31:0] primaryDataRead, secondaryDataRead;

  always #5 clk = ~clk;

  sram_banked_wrapper #(
    .BYTE_COUNT(BC), .ADDRESS_SIZE(AS), .BANK_COUNT(BK), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .primarySelect(primarySelect), .primaryWriteEnable(primaryWriteEnable),
    .primaryWriteMask(primaryWriteMask), .primaryAddress(primaryAddress),
    .primaryDataWrite(primaryDataWrite), .primaryBusy(primaryBusy),
    .primaryDataRead(primaryDataRead), .primaryReadValid(primaryReadValid),
    .secondarySelect(secondarySelect), .secondaryAddress(secondaryAddress),
    .secondaryBusy(secondaryBusy), .secondaryDataRead(secondaryDataRead),
    .secondaryReadValid(secondaryReadValid), .clearing(clearing)
  );

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    primarySelect = 1'b0; secondarySelect = 1'b0; primaryWriteEnable = 1'b0;
  endtask

  task automatic count_clear(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (clearing) n++;
      else if (n > 0) break;
    end
  endtask

  // Behavioural model: memory as a flat word array, clear as a cycle budget
  logic [31:0] m_mem [WORDS];
  bit          m_rstph = 1'b1, m_owe = 1'b0, m_pv = 1'b0, m_sv = 1'b0;
  int          m_clr = 0;
  logic [31:0] m_pd = '0, m_sd = '0;
  bit          m_ready, conf, e_pb, e_sb, prev_pb = 1'b0, prev_sb = 1'b0, pacc, sacc;

  always @(negedge clk) if (chk_en) begin
    m_ready = rst && !m_rstph && (m_clr == 0);
    conf = primarySelect && secondarySelect && (primaryAddress[1:0] == secondaryAddress[1:0]);
    e_pb = rst && primarySelect   && (!m_ready || (conf &&  m_owe));
    e_sb = rst && secondarySelect && (!m_ready || (conf && !m_owe));
    chk("primaryBusy",   64'(primaryBusy),   64'(e_pb));
    chk("secondaryBusy", 64'(secondaryBusy), 64'(e_sb));
    chk("clearing",      64'(clearing),      64'(rst && m_clr > 0));
    chk("primaryReadValid",   64'(primaryReadValid),   64'(m_pv));
    chk("secondaryReadValid", 64'(secondaryReadValid), 64'(m_sv));
    chk("primaryDataRead",    64'(primaryDataRead),    64'(m_pd));
    chk("secondaryDataRead",  64'(secondaryDataRead),  64'(m_sd));
    if (m_ready) begin
      chk("primary_busy_twice",   64'(primaryBusy && prev_pb),   64'(0));
      chk("secondary_busy_twice", 64'(secondaryBusy && prev_sb), 64'(0));
    end
    prev_pb = m_ready && primaryBusy;
    prev_sb = m_ready && secondaryBusy;

    if (!rst) begin
      m_rstph = 1'b1; m_clr = 0; m_owe = 1'b0;
      m_pv = 1'b0; m_sv = 1'b0; m_pd = '0; m_sd = '0;
    end else if (m_rstph) begin
      m_rstph = 1'b0; m_clr = ROWS; m_pv = 1'b0; m_sv = 1'b0;
    end else if (m_clr > 0) begin
      for (int b = 0; b < BK; b++) m_mem[(ROWS - m_clr) * BK + b] = '0;
      m_clr--; m_pv = 1'b0; m_sv = 1'b0;
    end else begin
      pacc = primarySelect   && !e_pb;
      sacc = secondarySelect && !e_sb;
      m_owe = conf && !m_owe;
      m_pv = pacc && !primaryWriteEnable;
      m_sv = sacc;
      if (m_pv) m_pd = m_mem[primaryAddress];
      if (m_sv) m_sd = m_mem[secondaryAddress];
      if (pacc && primaryWriteEnable)
        for (int i = 0; i < BC; i++)
          if (primaryWriteMask[i]) m_mem[primaryAddress][8*i +: 8] = primaryDataWrite[8*i +: 8];
    end
  end

  int  n;
  bit  pb, sb;

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    tick();
    chk_en = 1'b1;
    chk("rst_valid", 64'(primaryReadValid), 64'(0));
    chk("rst_data",  64'(primaryDataRead),  64'(0));
    chk("rst_clearing", 64'(clearing), 64'(0));
    primarySelect = 1'b1; secondarySelect = 1'b1;
    primaryAddress = 6'h00; secondaryAddress = 6'h08;
    #1;
    chk("rst_pbusy", 64'(primaryBusy),   64'(0));
    chk("rst_sbusy", 64'(secondaryBusy), 64'(0));
    tick(); tick();
    idle();
    rst = 1'b1;
    count_clear(n);
    chk("clear_cycles", 64'(n), 64'(16));

    // Freshly cleared word reads zero
    primarySelect = 1'b1; primaryAddress = 6'h2A;
    tick();
    chk("clear_read_valid", 64'(primaryReadValid), 64'(1));
    chk("clear_read_data",  64'(primaryDataRead),  64'h0);
    idle();

    // Byte mask
    primarySelect = 1'b1; primaryWriteEnable = 1'b1; primaryAddress = 6'h05;
    primaryWriteMask = 4'b1111; primaryDataWrite = 32'hAABBCCDD;
    tick();
    primaryWriteMask = 4'b0101; primaryDataWrite = 32'h11223344;
    tick();
    primaryWriteEnable = 1'b0;
    #1;
    chk("mask_read_busy", 64'(primaryBusy), 64'(0));
    tick();
    chk("mask_valid", 64'(primaryReadValid), 64'(1));
    chk("mask_data",  64'(primaryDataRead),  64'hAA22CC44);
    idle();
    tick();
    chk("mask_valid_pulse", 64'(primaryReadValid), 64'(0));
    chk("mask_data_hold",   64'(primaryDataRead),  64'hAA22CC44);

    // Parallel banks
    primarySelect = 1'b1; primaryWriteEnable = 1'b1; primaryAddress = 6'h04;
    primaryWriteMask = 4'hF; primaryDataWrite = 32'h0A0B0C0D;
    tick();
    primaryWriteEnable = 1'b0;
    secondarySelect = 1'b1; secondaryAddress = 6'h05;
    #1;
    chk("par_pbusy", 64'(primaryBusy),   64'(0));
    chk("par_sbusy", 64'(secondaryBusy), 64'(0));
    tick();
    chk("par_pvalid", 64'(primaryReadValid),   64'(1));
    chk("par_svalid", 64'(secondaryReadValid), 64'(1));
    chk("par_pdata",  64'(primaryDataRead),    64'h0A0B0C0D);
    chk("par_sdata",  64'(secondaryDataRead),  64'hAA22CC44);
    idle();
    tick();

    // Conflict fairness on bank 0
    primarySelect = 1'b1; secondarySelect = 1'b1;
    primaryAddress = 6'h00; secondaryAddress = 6'h08;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("fair_sbusy_%0d", k), 64'(secondaryBusy), 64'(k % 2 == 0));
      chk($sformatf("fair_pbusy_%0d", k), 64'(primaryBusy),   64'(k % 2 == 1));
      tick();
    end
    idle();
    tick();

    // Read after write
    primarySelect = 1'b1; primaryWriteEnable = 1'b1; primaryAddress = 6'h3F;
    primaryWriteMask = 4'hF; primaryDataWrite = 32'hDEADBEEF;
    tick();
    primaryWriteEnable = 1'b0;
    tick();
    chk("raw_valid", 64'(primaryReadValid), 64'(1));
    chk("raw_data",  64'(primaryDataRead),  64'hDEADBEEF);
    idle();
    tick();

    // Randomized traffic; requests are held while busy
    pb = 1'b0; sb = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!pb) begin
        primarySelect      = ($urandom_range(0, 3) != 0);
        primaryWriteEnable = 1'($urandom_range(0, 1));
        primaryWriteMask   = 4'($urandom_range(0, 15));
        primaryAddress     = 6'($urandom_range(0, 63));
        primaryDataWrite   = $urandom;
      end
      if (!sb) begin
        secondarySelect  = ($urandom_range(0, 3) != 0);
        secondaryAddress = 6'($urandom_range(0, 63));
      end
      #1;
      pb = primarySelect && primaryBusy;
      sb = secondarySelect && secondaryBusy;
      tick();
    end
    idle();
    tick();

    // Reset mid-clear restarts the sweep
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    repeat (7) tick();
    chk("midclear_active", 64'(clearing), 64'(1));
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    count_clear(n);
    chk("midclear_cycles", 64'(n), 64'(16));

    // Reset in the request cycle suppresses the read pulse
    primarySelect = 1'b1; primaryAddress = 6'h03; rst = 1'b0;
    #1;
    chk("rstread_busy", 64'(primaryBusy), 64'(0));
    tick();
    chk("rstread_valid", 64'(primaryReadValid), 64'(0));
    chk("rstread_data",  64'(primaryDataRead),  64'h0);
    idle();
    rst = 1'b1;
    count_clear(n);
    chk("final_clear_cycles", 64'(n), 64'(16));
    tick(); tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
